// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] AluOp;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       cause_write;
  logic       epc_write;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst,
           cause_write, epc_write, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst,
           cause_write, epc_write, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Define MC_CTRL_EXC_EN to trap unknown opcodes into a one-cycle exception state.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input logic                          clk,
  input logic                          reset_n,
  multicycle_main_control_if.master    bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EX     = 4'd7,
    S_R_WB     = 4'd8,
    S_BEQ      = 4'd9,
    S_JMP      = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_EXC      = 4'd13
  } state_t;

  state_t     state_q, state_d;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, memto_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst;
`ifdef MC_CTRL_EXC_EN
  logic       cause_wr, epc_wr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Outputs decode from state only, except FETCH where the IR/PC load waits on mem_ready.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    memto_reg     = 1'b0;
    ir_write      = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
`ifdef MC_CTRL_EXC_EN
    cause_wr      = 1'b0;
    epc_wr        = 1'b0;
`endif
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BEQ can finish in one execute cycle.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MC_CTRL_EXC_EN
          default:      state_d = S_EXC;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.opcode == OP_LW)      state_d = S_MEM_RD;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
        else                          state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: reg_write = 1'b1;
`ifdef MC_CTRL_EXC_EN
      S_EXC: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        cause_wr  = 1'b1;
        epc_wr    = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.MemtoReg    = memto_reg;
  assign bus.IRWrite     = ir_write;
  assign bus.PCSource    = pc_source;
  assign bus.AluOp       = alu_op;
  assign bus.AluSrcA     = alu_src_a;
  assign bus.AluSrcB     = alu_src_b;
  assign bus.RegWrite    = reg_write;
  assign bus.RegDst      = reg_dst;
  assign bus.state       = state_q;
`ifdef MC_CTRL_EXC_EN
  assign bus.cause_write = cause_wr;
  assign bus.epc_write   = epc_wr;
`else
  assign bus.cause_write = 1'b0;
  assign bus.epc_write   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control: instruction-level reference model
// (per-opcode state walk plus per-state output table) checked every cycle.
module tb_multicycle_main_control;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_main_control_if bus();

  multicycle_main_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int    compared   = 0;
  int    mismatched = 0;
  int    exp_state  = 0;
  logic  exp_mr     = 1'b0;
  bit    exp_valid  = 1'b0;
  int    lit_seq    = 0;
  int    lit_done   = 0;
  int    lit_got    = 0;
  int    lit_exp    = 0;
  string lit_name   = "";
  int    cyc        = 0;

  // Output vector order:
  // PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource[2],AluOp[2],
  // AluSrcA,AluSrcB[2],RegWrite,RegDst,cause_write,epc_write
  function automatic logic [17:0] dut_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.AluOp, bus.AluSrcA,
            bus.AluSrcB, bus.RegWrite, bus.RegDst, bus.cause_write, bus.epc_write};
  endfunction

  // Output table straight from the state description.
  function automatic logic [17:0] exp_out(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, cw, ew;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, cw, ew} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      11: begin asa = 1; asb = 2'b10; aop = 2'b11; end
      12: rw = 1;
`ifdef MC_CTRL_EXC_EN
      13: begin pcw = 1; pcs = 2'b11; cw = 1; ew = 1; end
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, cw, ew};
  endfunction

  initial begin : compare
    logic [17:0] got, want;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_valid) begin
        compared++;
        got  = dut_vec();
        want = exp_out(exp_state, exp_mr);
        if (got !== want || bus.state !== 4'(exp_state)) begin
          mismatched++;
          $display("FAIL cycle %0d ctrl: got state %0d outputs %b, required state %0d outputs %b",
                   cyc, bus.state, got, exp_state, want);
        end
      end
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        compared++;
        if (lit_got != lit_exp) begin
          mismatched++;
          $display("FAIL %s: got %0d, required %0d", lit_name, lit_got, lit_exp);
        end
      end
    end
  end

  task automatic lit(input string n, input int got, input int ex);
    lit_name = n;
    lit_got  = got;
    lit_exp  = ex;
    lit_seq++;
  endtask

  task automatic step(input int st, input logic mr, input logic [5:0] op);
    bus.mem_ready = mr;
    bus.opcode    = op;
    exp_state     = st;
    exp_mr        = mr;
    exp_valid     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] opd(input int st, input logic [5:0] op);
    return (st == 2 || st == 3) ? op : 6'($urandom_range(63));
  endfunction

  // Instruction-level model: the state walk each opcode class takes.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, output int ncyc);
    int path[$];
    int w;
    case (op)
      6'h23:   path = '{1, 2, 3, 4, 5};
      6'h2B:   path = '{1, 2, 3, 6};
      6'h00:   path = '{1, 2, 7, 8};
      6'h08:   path = '{1, 2, 11, 12};
      6'h04:   path = '{1, 2, 9};
      6'h02:   path = '{1, 2, 10};
`ifdef MC_CTRL_EXC_EN
      default: path = '{1, 2, 13};
`else
      default: path = '{1, 2};
`endif
    endcase
    ncyc = 0;
    foreach (path[i]) begin
      if (path[i] == 1 || path[i] == 4 || path[i] == 6) begin
        w = (path[i] == 1) ? wf : wm;
        repeat (w) begin step(path[i], 1'b0, opd(path[i], op)); ncyc++; end
        step(path[i], 1'b1, opd(path[i], op));
        ncyc++;
      end else begin
        step(path[i], 1'($urandom_range(1)), opd(path[i], op));
        ncyc++;
      end
    end
  endtask

  logic [5:0] known_ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
  logic [5:0] bad_ops   [5] = '{6'h3F, 6'h01, 6'h05, 6'h10, 6'h2A};

  initial begin : stim
    int n, wf, wm;
    logic [5:0] op;
    reset_n       = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(0, 1'($urandom_range(1)), 6'($urandom_range(63)));
    reset_n = 1'b1;
    step(0, 1'($urandom_range(1)), 6'($urandom_range(63)));

    // Directed latencies with mem_ready high, then a stalled SW.
    run_instr(6'h23, 0, 0, n); lit("lw_latency", n, 5);
    run_instr(6'h00, 0, 0, n); lit("rtype_latency", n, 4);
    run_instr(6'h2B, 0, 0, n); lit("sw_latency", n, 4);
    run_instr(6'h08, 0, 0, n); lit("addi_latency", n, 4);
    run_instr(6'h04, 0, 0, n); lit("beq_latency", n, 3);
    run_instr(6'h02, 0, 0, n); lit("j_latency", n, 3);
    run_instr(6'h3F, 0, 0, n);
`ifdef MC_CTRL_EXC_EN
    lit("unknown_latency", n, 3);
`else
    lit("unknown_latency", n, 2);
`endif
    run_instr(6'h2B, 3, 2, n); lit("sw_stall_latency", n, 9);

    // Abort an LW while it waits in MEM_RD.
    step(1, 1'b1, 6'($urandom_range(63)));
    step(2, 1'($urandom_range(1)), 6'h23);
    step(3, 1'($urandom_range(1)), 6'h23);
    step(4, 1'b0, 6'($urandom_range(63)));
    reset_n = 1'b0;
    #1;
    lit("reset_abort_state_outputs", int'({bus.state, dut_vec()}), 0);
    repeat (3) step(0, 1'($urandom_range(1)), 6'($urandom_range(63)));
    reset_n = 1'b1;
    step(0, 1'($urandom_range(1)), 6'($urandom_range(63)));

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(9) == 0) op = bad_ops[$urandom_range(4)];
      else                        op = known_ops[$urandom_range(5)];
      wf = ($urandom_range(1) == 0) ? 0 : $urandom_range(3);
      wm = ($urandom_range(1) == 0) ? 0 : $urandom_range(3);
      run_instr(op, wf, wm, n);
    end

    step(1, 1'b0, 6'($urandom_range(63)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
